// File: rtl/mdu_defs.sv
// Shared definitions for the iterative multiply/divide unit: mdop encodings,
// FSM state encoding and the default operand width.
package mdu_defs;

    localparam int unsigned WidthDefault = 32;

    localparam logic [2:0] MdopMult  = 3'b000;
    localparam logic [2:0] MdopMultu = 3'b001;
    localparam logic [2:0] MdopDiv   = 3'b010;
    localparam logic [2:0] MdopDivu  = 3'b011;
    localparam logic [2:0] MdopMthi  = 3'b100;
    localparam logic [2:0] MdopMtlo  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y = en ? -x : x.
module mdu_negate #(
    parameter int unsigned W = 64
) (
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = en ? (~x + W'(1)) : x;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU in 34 edges,
// MTHI/MTLO in one; magnitude datapath with sign fix-up in a final state.
module mul_div_unit
    import mdu_defs::*;
#(
    parameter int unsigned WIDTH = WidthDefault,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q, md_q, a_q;
    logic               busy_q, done_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;

    assign a_neg = ~mdop[0] & a[WIDTH-1];
    assign b_neg = ~mdop[0] & b[WIDTH-1];

    mdu_negate #(.W(WIDTH)) u_abs_a (.en(a_neg), .x(a), .y(a_abs));
    mdu_negate #(.W(WIDTH)) u_abs_b (.en(b_neg), .x(b), .y(b_abs));

    // One iteration of each algorithm. Multiply keeps the multiplier in the low
    // half of acc_q; divide keeps the dividend/quotient there.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_rem_next, div_quo_next;

    always_comb begin
        mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, md_q} : '0);
        mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift    = {rem_q, acc_q[WIDTH-1]};
        div_diff     = div_shift - {1'b0, md_q};
        div_rem_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_quo_next = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH-1:0]   rem_fix;

    assign fix_in = is_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

    mdu_negate #(.W(2*WIDTH)) u_fix_res (.en(neg_res_q), .x(fix_in), .y(fix_out));
    mdu_negate #(.W(WIDTH))   u_fix_rem (.en(neg_rem_q), .x(rem_q), .y(rem_fix));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            acc_q      <= '0;
            rem_q      <= '0;
            md_q       <= '0;
            a_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (mdop == MdopMthi) begin
                            hi_q <= a;
                        end else if (mdop == MdopMtlo) begin
                            lo_q <= a;
                        end else if (!mdop[2]) begin
                            is_div_q   <= mdop[1];
                            neg_res_q  <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            div_zero_q <= mdop[1] & (b == '0);
                            a_q        <= a;
                            md_q       <= mdop[1] ? b_abs : a_abs;
                            acc_q      <= {{WIDTH{1'b0}}, (mdop[1] ? a_abs : b_abs)};
                            rem_q      <= '0;
                            cnt_q      <= '0;
                            dz_q       <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (is_div_q) begin
                        acc_q <= {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
                        rem_q <= div_rem_next;
                    end else begin
                        acc_q <= mul_next;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (is_div_q && div_zero_q) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                        dz_q <= 1'b1;
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= fix_out[WIDTH-1:0];
                    end else begin
                        {hi_q, lo_q} <= fix_out;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus model-driven random
// ops through a result scoreboard, and hand-written handshake/reset sequences.
module tb_mul_div_unit;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .clrn(clrn), .start(start), .mdop(mdop), .a(a), .b(b),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on native SV arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] ma, input logic [31:0] mb,
                         output exp_t e);
        logic signed [63:0] sp;
        logic [63:0] up;
        e.dz = 1'b0;
        case (op)
            MdopMult: begin
                sp = $signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb});
                {e.hi, e.lo} = sp;
            end
            MdopMultu: begin
                up = {32'b0, ma} * {32'b0, mb};
                {e.hi, e.lo} = up;
            end
            default: begin
                if (mb == 0) begin
                    e.hi = ma; e.lo = '1; e.dz = 1'b1;
                end else if (op == MdopDiv && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    e.hi = 0; e.lo = 32'h8000_0000;
                end else if (op == MdopDiv) begin
                    e.lo = $signed(ma) / $signed(mb);
                    e.hi = $signed(ma) % $signed(mb);
                end else begin
                    e.lo = ma / mb;
                    e.hi = ma % mb;
                end
            end
        endcase
    endtask

    // Scoreboard: every done pulse pops and compares one expected result.
    always @(negedge clk) begin
        if (clrn && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
                check("sb_dz", 32'(dz), 32'(e.dz));
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] da, input logic [31:0] db);
        start = 1'b1; mdop = op; a = da; b = db;
    endtask

    // Counts negedges until done is seen, bounded.
    task automatic wait_done(input logic drop_start, output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (drop_start) start = 1'b0;
            n++;
        end while (!done && n < 40);
        if (!done) begin
            failures++; checks++;
            $display("FAIL done_timeout: got no done after %0d edges required 34", n);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] da, input logic [31:0] db,
                          input exp_t e);
        int n;
        @(negedge clk);
        drive(op, da, db);
        sb_q.push_back(e);
        wait_done(1'b1, n);
        check("latency", n, 34);
    endtask

    vec_t vecs[11];

    initial begin
        exp_t e;
        int   n;
        logic [2:0] rop;

        vecs[0]  = '{MdopMult,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[1]  = '{MdopMultu, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
        vecs[2]  = '{MdopDiv,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{MdopDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4]  = '{MdopDivu,  32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{MdopDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[6]  = '{MdopDiv,   32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{MdopMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[8]  = '{MdopMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        vecs[9]  = '{MdopDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{MdopMult,  32'd0,         32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0};

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dz",   32'(dz),   0);
        check("rst_hi",   hi, 0);
        check("rst_lo",   lo, 0);
        @(negedge clk);
        clrn = 1'b1;

        foreach (vecs[i]) begin
            e = '{vecs[i].hi, vecs[i].lo, vecs[i].dz};
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            model(rop, ra, rb, e);
            run_op(rop, ra, rb, e);
        end

        // MTHI then MTLO in consecutive idle cycles
        @(negedge clk);
        drive(MdopMthi, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(busy | done), 0);
        drive(MdopMtlo, 32'h1, 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h1);
        check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
        check("mtlo_done", 32'(done), 0);

        // MTLO issued while busy is ignored
        @(negedge clk);
        drive(MdopDivu, 32'd1000, 32'd33);
        model(MdopDivu, 32'd1000, 32'd33, e);
        sb_q.push_back(e);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        drive(MdopMtlo, 32'h55, 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("mtlo_busy_lo", lo, 32'h1);
        wait_done(1'b1, n);
        check("mtlo_busy_latency", n + 4, 34);

        // Second start pulse at E5 is ignored
        @(negedge clk);
        drive(MdopMult, 32'd123, 32'd456);
        model(MdopMult, 32'd123, 32'd456, e);
        sb_q.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 4) drive(MdopDivu, 32'd999, 32'd3);
        end
        wait_done(1'b1, n);
        check("restart_latency", n + 4, 34);

        // Start held through the done cycle: back-to-back acceptance
        @(negedge clk);
        drive(MdopMultu, 32'h0001_0000, 32'h0001_0000);
        model(MdopMultu, 32'h0001_0000, 32'h0001_0000, e);
        sb_q.push_back(e);
        wait_done(1'b0, n);
        check("b2b_first_latency", n, 34);
        drive(MdopDiv, 32'hFFFF_FF9C, 32'd7);
        model(MdopDiv, 32'hFFFF_FF9C, 32'd7, e);
        sb_q.push_back(e);
        @(negedge clk);
        check("b2b_no_gap", 32'(busy), 1);
        start = 1'b0;
        wait_done(1'b0, n);
        check("b2b_second_latency", n + 1, 34);

        // dz is sticky and cleared by the next accepted start
        e = '{32'h7, 32'hFFFF_FFFF, 1'b1};
        run_op(MdopDivu, 32'h7, 32'h0, e);
        @(negedge clk);
        check("dz_sticky", 32'(dz), 1);
        drive(MdopMult, 32'hFFFF_FFFF, 32'd2);
        sb_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        @(negedge clk);
        start = 1'b0;
        check("dz_cleared", 32'(dz), 0);
        wait_done(1'b0, n);
        check("dz_clear_latency", n + 1, 34);

        // Reset mid-CALC aborts the operation
        @(negedge clk);
        drive(MdopMult, 32'd7, 32'd9);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        @(negedge clk);
        clrn = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midrst_no_done", n, 0);
        check("midrst_hi_after", hi, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
